// File: rtl/dwt_haar_stream.sv
// dwt_haar_stream: streaming one-level Haar DWT stage.
// Samples are taken one per cycle, paired within s_last-delimited frames, and
// each pair is turned into an approximation/detail coefficient pair scaled by
// 181/256 (about 1/sqrt(2)) through a two-stage pipeline with full backpressure.
// Optional feature macro: DWT_HAAR_SAT_EN (saturate coefficients instead of
// wrapping them to DATA_W bits).
module dwt_haar_stream #(
  parameter int DATA_W = 16,
  parameter int IDX_W  = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic signed [DATA_W-1:0] s_data,
  input  logic                     s_last,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic signed [DATA_W-1:0] m_ca,
  output logic signed [DATA_W-1:0] m_cd,
  output logic [IDX_W-1:0]         m_idx,
  output logic                     m_last,
  output logic                     busy
);

  localparam int P_W = DATA_W + 8;  // product width
  localparam int S_W = DATA_W + 9;  // sum/difference width

  typedef enum logic {ST_EVEN = 1'b0, ST_ODD = 1'b1} pair_state_t;

  pair_state_t              r_state;
  logic signed [DATA_W-1:0] r_x0;

  logic                     r_st1_valid;
  logic signed [DATA_W-1:0] r_st1_x0;
  logic signed [DATA_W-1:0] r_st1_x1;
  logic                     r_st1_last;
  logic [IDX_W-1:0]         r_st1_idx;
  logic [IDX_W-1:0]         r_pair_cnt;

  logic                     w_stage2_free;
  logic                     w_stage1_free;
  logic                     w_xfer;
  logic                     w_launch;
  logic signed [DATA_W-1:0] w_launch_x0;

  logic signed [P_W-1:0]    w_p0;
  logic signed [P_W-1:0]    w_p1;
  logic signed [S_W-1:0]    w_sum;
  logic signed [S_W-1:0]    w_diff;
  logic signed [S_W-1:0]    w_sum_sh;
  logic signed [S_W-1:0]    w_diff_sh;
  logic signed [DATA_W-1:0] w_ca;
  logic signed [DATA_W-1:0] w_cd;

  // Multiply by 181 = 128 + 32 + 16 + 4 + 1 using shifts and adds only.
  function automatic logic signed [P_W-1:0] mul181(input logic signed [DATA_W-1:0] x);
    logic signed [P_W-1:0] xe;
    xe = P_W'(x);
    return (xe <<< 7) + (xe <<< 5) + (xe <<< 4) + (xe <<< 2) + xe;
  endfunction

`ifdef DWT_HAAR_SAT_EN
  // Clamp to the signed DATA_W range when the upper bits are not a pure sign extension.
  function automatic logic signed [DATA_W-1:0] sat_narrow(input logic signed [S_W-1:0] v);
    logic [S_W-DATA_W:0] hi;
    hi = v[S_W-1:DATA_W-1];
    if ((&hi) || !(|hi))
      return v[DATA_W-1:0];
    else if (v[S_W-1])
      return {1'b1, {(DATA_W-1){1'b0}}};
    else
      return {1'b0, {(DATA_W-1){1'b1}}};
  endfunction
`endif

  // Handshake chain: a stage may accept when it is empty or draining this cycle.
  // s_ready therefore depends combinationally on m_ready.
  assign w_stage2_free = !m_valid || m_ready;
  assign w_stage1_free = !r_st1_valid || w_stage2_free;
  assign s_ready       = w_stage1_free;
  assign w_xfer        = s_valid && s_ready;

  // A pair launches on the second sample, or on a lone tail sample seen in EVEN.
  assign w_launch    = w_xfer && ((r_state == ST_ODD) || s_last);
  assign w_launch_x0 = (r_state == ST_ODD) ? r_x0 : s_data;

  assign busy = (r_state == ST_ODD) || r_st1_valid || m_valid;

  // Butterfly on the stage-1 pair; floor rounding comes from the arithmetic shift.
  assign w_p0      = mul181(r_st1_x0);
  assign w_p1      = mul181(r_st1_x1);
  assign w_sum     = S_W'(w_p0) + S_W'(w_p1);
  assign w_diff    = S_W'(w_p0) - S_W'(w_p1);
  assign w_sum_sh  = w_sum >>> 8;
  assign w_diff_sh = w_diff >>> 8;

`ifdef DWT_HAAR_SAT_EN
  assign w_ca = sat_narrow(w_sum_sh);
  assign w_cd = sat_narrow(w_diff_sh);
`else
  // Plain two's-complement wrap: keep the low DATA_W bits.
  logic [2*(S_W-DATA_W)-1:0] w_unused_hi;
  assign w_unused_hi = {w_sum_sh[S_W-1:DATA_W], w_diff_sh[S_W-1:DATA_W]};
  assign w_ca = w_sum_sh[DATA_W-1:0];
  assign w_cd = w_diff_sh[DATA_W-1:0];
`endif

  // Pair FSM: hold the even sample until its partner (or end of frame) arrives.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_EVEN;
      r_x0    <= '0;
    end else if (w_xfer) begin
      case (r_state)
        ST_EVEN: begin
          if (!s_last) begin
            r_x0    <= s_data;
            r_state <= ST_ODD;
          end
        end
        ST_ODD: begin
          r_state <= ST_EVEN;
        end
        default: r_state <= ST_EVEN;
      endcase
    end
  end

  // Stage 1: capture the launched pair and stamp it with the in-frame pair index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_st1_valid <= 1'b0;
      r_st1_x0    <= '0;
      r_st1_x1    <= '0;
      r_st1_last  <= 1'b0;
      r_st1_idx   <= '0;
      r_pair_cnt  <= '0;
    end else if (w_launch) begin
      r_st1_valid <= 1'b1;
      r_st1_x0    <= w_launch_x0;
      r_st1_x1    <= s_data;
      r_st1_last  <= s_last;
      r_st1_idx   <= r_pair_cnt;
      r_pair_cnt  <= s_last ? '0 : r_pair_cnt + IDX_W'(1);
    end else if (w_stage2_free) begin
      r_st1_valid <= 1'b0;
    end
  end

  // Stage 2: register coefficients; fields are frozen while the sink stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0;
      m_ca    <= '0;
      m_cd    <= '0;
      m_idx   <= '0;
      m_last  <= 1'b0;
    end else if (w_stage2_free) begin
      m_valid <= r_st1_valid;
      if (r_st1_valid) begin
        m_ca   <= w_ca;
        m_cd   <= w_cd;
        m_idx  <= r_st1_idx;
        m_last <= r_st1_last;
      end
    end
  end

endmodule

// File: tb/tb_dwt_haar_stream.sv
// Directed testbench for dwt_haar_stream (DATA_W=16, IDX_W=3).
// Inputs change 1ns after the rising edge; outputs are observed on the falling edge.
module tb_dwt_haar_stream;

  logic               clk;
  logic               rst_n;
  logic               s_valid;
  logic               s_ready;
  logic signed [15:0] s_data;
  logic               s_last;
  logic               m_valid;
  logic               m_ready;
  logic signed [15:0] m_ca;
  logic signed [15:0] m_cd;
  logic [2:0]         m_idx;
  logic               m_last;
  logic               busy;

  typedef struct packed {
    logic [15:0] ca;
    logic [15:0] cd;
    logic [2:0]  idx;
    logic        last;
  } pair_t;

  pair_t got_q[$];
  pair_t exp_q[$];
  pair_t prev_out;
  bit    prev_stall;
  bit    saw_block;
  int    n_vec;
  int    n_miss;

  dwt_haar_stream #(.DATA_W(16), .IDX_W(3)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_data  (s_data),
    .s_last  (s_last),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_ca    (m_ca),
    .m_cd    (m_cd),
    .m_idx   (m_idx),
    .m_last  (m_last),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1);
  end

  task automatic check_val(input string tag, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, want %0d", tag, act, exp);
    end
  endtask

  // Output monitor: collects accepted pairs and checks stability under stall.
  always @(negedge clk) begin
    if (rst_n) begin
      if (m_valid && m_ready)
        got_q.push_back(pair_t'{m_ca, m_cd, m_idx, m_last});
      if (m_valid && prev_stall) begin
        check_val("hold_ca",   int'(m_ca), int'($signed(prev_out.ca)));
        check_val("hold_cd",   int'(m_cd), int'($signed(prev_out.cd)));
        check_val("hold_idx",  int'(m_idx), int'(prev_out.idx));
        check_val("hold_last", int'(m_last), int'(prev_out.last));
      end
      prev_stall <= m_valid && !m_ready;
      prev_out   <= pair_t'{m_ca, m_cd, m_idx, m_last};
    end else begin
      prev_stall <= 1'b0;
    end
  end

  // Present one sample starting at posedge+1ns; returns at posedge+1ns after it transfers.
  task automatic send(input int d, input bit l);
    int n;
    n = 0;
    s_valid = 1'b1;
    s_data  = 16'(d);
    s_last  = l;
    do begin
      @(negedge clk);
      n++;
    end while (!s_ready && n < 60);
    if (!s_ready) check_val("s_ready_timeout", int'(s_ready), 1);
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic ex(input int ca, input int cd, input int idx, input bit last);
    pair_t e;
    e.ca   = ca[15:0];
    e.cd   = cd[15:0];
    e.idx  = idx[2:0];
    e.last = last;
    exp_q.push_back(e);
  endtask

  // Wait (bounded) for all expected pairs, then compare field by field.
  task automatic drain(input string name);
    int n;
    n = 0;
    while (got_q.size() < exp_q.size() && n < 300) begin
      @(posedge clk);
      n++;
    end
    repeat (3) @(posedge clk);
    #1;
    check_val({name, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      check_val($sformatf("%s_ca%0d", name, i),   int'($signed(got_q[i].ca)), int'($signed(exp_q[i].ca)));
      check_val($sformatf("%s_cd%0d", name, i),   int'($signed(got_q[i].cd)), int'($signed(exp_q[i].cd)));
      check_val($sformatf("%s_idx%0d", name, i),  int'(got_q[i].idx), int'(exp_q[i].idx));
      check_val($sformatf("%s_last%0d", name, i), int'(got_q[i].last), int'(exp_q[i].last));
    end
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    n_vec   = 0;
    n_miss  = 0;
    s_valid = 1'b0;
    s_data  = '0;
    s_last  = 1'b0;
    m_ready = 1'b1;
    rst_n   = 1'b0;
    saw_block = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_m_valid", int'(m_valid), 0);
    check_val("rst_m_ca",    int'(m_ca), 0);
    check_val("rst_m_cd",    int'(m_cd), 0);
    check_val("rst_m_idx",   int'(m_idx), 0);
    check_val("rst_m_last",  int'(m_last), 0);
    check_val("rst_busy",    int'(busy), 0);
    rst_n = 1'b1;
    #1;
    check_val("rst_s_ready", int'(s_ready), 1);
    @(posedge clk);
    #1;

    // Basic pair and latency: {100, 100(last)} -> cA 141, cD 0.
    send(100, 1'b0);
    send(100, 1'b1);
    check_val("lat_early_m_valid", int'(m_valid), 0);
    @(posedge clk);
    #1;
    check_val("lat_m_valid", int'(m_valid), 1);
    check_val("lat_m_ca", int'(m_ca), 141);
    ex(141, 0, 0, 1'b1);
    drain("t_basic");

    // Two pairs with sign change.
    send(256, 1'b0); send(0, 1'b0); send(-256, 1'b0); send(0, 1'b1);
    ex(181, 181, 0, 1'b0);
    ex(-181, -181, 1, 1'b1);
    drain("t_sign");

    // Odd-length frame: lone tail becomes (x, x).
    send(256, 1'b0); send(0, 1'b0); send(256, 1'b1);
    ex(181, 181, 0, 1'b0);
    ex(362, 0, 1, 1'b1);
    drain("t_odd");
    check_val("t_odd_idle_busy", int'(busy), 0);

    // One-sample frames and floor rounding of a negative result.
    send(256, 1'b1);
    send(-1, 1'b0); send(0, 1'b1);
    ex(362, 0, 0, 1'b1);
    ex(-1, -1, 0, 1'b1);
    drain("t_short");

    // Overflow behaviour at both extremes.
    send(32767, 1'b0); send(32767, 1'b1);
    send(-32768, 1'b0); send(-32768, 1'b1);
`ifdef DWT_HAAR_SAT_EN
    ex(32767, 0, 0, 1'b1);
    ex(-32768, 0, 0, 1'b1);
`else
    ex(-19202, 0, 0, 1'b1);
    ex(19200, 0, 0, 1'b1);
`endif
    drain("t_ovf");

    // 4-pair frame with the sink stalled for 5 cycles mid-stream.
    fork
      begin
        send(256, 1'b0); send(0, 1'b0); send(-256, 1'b0); send(0, 1'b0);
        send(512, 1'b0); send(256, 1'b0); send(0, 1'b0); send(256, 1'b1);
      end
      begin
        repeat (3) @(posedge clk);
        #1 m_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1 m_ready = 1'b1;
      end
      begin
        repeat (14) begin
          @(negedge clk);
          if (s_valid && !s_ready) saw_block = 1'b1;
        end
      end
    join
    ex(181, 181, 0, 1'b0);
    ex(-181, -181, 1, 1'b0);
    ex(543, 181, 2, 1'b0);
    ex(181, -181, 3, 1'b1);
    drain("t_stall");
    check_val("t_stall_s_ready_dropped", int'(saw_block), 1);

    // Index wrap: 10 pairs in one frame, idx runs 0..7,0,1.
    for (int k = 0; k < 10; k++) begin
      send(256, 1'b0);
      send(0, (k == 9));
      ex(181, 181, k % 8, (k == 9));
    end
    drain("t_wrap");

    // Reset while a pair sits in stage 2 and x0 is held.
    m_ready = 1'b0;
    send(100, 1'b0); send(100, 1'b1); send(500, 1'b0);
    check_val("t_rst_pre_busy", int'(busy), 1);
    rst_n = 1'b0;
    #1;
    check_val("t_rst_m_valid", int'(m_valid), 0);
    check_val("t_rst_busy", int'(busy), 0);
    check_val("t_rst_m_ca", int'(m_ca), 0);
    @(posedge clk);
    #1;
    rst_n   = 1'b1;
    m_ready = 1'b1;
    got_q.delete();
    @(posedge clk);
    #1;
    send(1000, 1'b0); send(-1000, 1'b1);
    ex(0, 1414, 0, 1'b1);
    drain("t_rst_after");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
